// File: rtl/img_pkg.sv
// Shared definitions for the image frame sequencer: operation codes,
// pixel width and the frame-level state encoding.
package img_pkg;

   // RGB888 pixel width
   localparam int PIX_W = 24;

   // Pixel processor operation codes
   localparam logic [1:0] OP_INVERT = 2'b00;
   localparam logic [1:0] OP_THRESH = 2'b01;
   localparam logic [1:0] OP_BRIGHT = 2'b10;
   localparam logic [1:0] OP_GRAY   = 2'b11;

   // Frame sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } seq_state_t;

endpackage

// File: rtl/image_raster_counter.sv
// Raster-scan counter: walks x across a line, then y down the frame, and
// keeps the linear index y*width+x as a running count (no multiplier).
module image_raster_counter
   import img_pkg::*;
#(
   parameter int DIM_W  = 10,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   output logic [ADDR_W-1:0] idx,
   output logic              line_end,
   output logic              last
);

   logic [DIM_W-1:0]  x_q, x_d;
   logic [DIM_W-1:0]  y_q, y_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   // End-of-line and end-of-frame flags for the current position
   always_comb begin
      line_end = (x_q == width - DIM_W'(1));
      last     = line_end && (y_q == height - DIM_W'(1));
   end

   // Advance position on enable; the whole counter wraps to 0 after the last pixel
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      idx_d = idx_q;
      if (clr) begin
         x_d   = '0;
         y_d   = '0;
         idx_d = '0;
      end else if (en) begin
         if (last) begin
            x_d   = '0;
            y_d   = '0;
            idx_d = '0;
         end else if (line_end) begin
            x_d   = '0;
            y_d   = y_q + DIM_W'(1);
            idx_d = idx_q + ADDR_W'(1);
         end else begin
            x_d   = x_q + DIM_W'(1);
            idx_d = idx_q + ADDR_W'(1);
         end
      end
   end

   // Position registers
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         idx_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         idx_q <= idx_d;
      end
   end

   assign idx = idx_q;

endmodule

// File: rtl/image_frame_sequencer.sv
// Frame controller: latches a frame configuration on start, raster-reads the
// source memory, streams pixels through the external processor and writes the
// results linearly into the destination memory. ADDR_W must be >= 2*DIM_W so
// the width*height product and the linear index fit.
module image_frame_sequencer
   import img_pkg::*;
#(
   parameter int DIM_W  = 10,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  img_width,
   input  logic [DIM_W-1:0]  img_height,
   input  logic [1:0]        op_sel,
   input  logic [7:0]        thresh_cfg,
   input  logic [7:0]        bright_cfg,
   input  logic              pause,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic [PIX_W-1:0]  proc_pixel_in,
   output logic              proc_valid_in,
   output logic [1:0]        proc_op,
   output logic [7:0]        proc_thresh,
   output logic [7:0]        proc_bright,
   input  logic [PIX_W-1:0]  proc_pixel_out,
   input  logic              proc_valid_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              line_done
);

   seq_state_t        state_q, state_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [ADDR_W-1:0] total_q, total_d;
   logic [1:0]        op_q, op_d;
   logic [7:0]        thresh_q, thresh_d;
   logic [7:0]        bright_q, bright_d;
   logic              pvalid_q, pvalid_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

   logic              start_ok;
   logic              dim_zero;
   logic              raster_line_end;
   logic              raster_last;
   logic              writes_complete;

   assign start_ok = (state_q == ST_IDLE) && start;
   assign dim_zero = (img_width == '0) || (img_height == '0);

   // Counting the write happening this cycle lets done follow the last write directly
   assign writes_complete = ((wr_addr_q + ADDR_W'(wr_en)) == total_q);

   image_raster_counter #(
      .DIM_W  (DIM_W),
      .ADDR_W (ADDR_W)
   ) u_raster (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_ok),
      .en       (rd_en),
      .width    (width_q),
      .height   (height_q),
      .idx      (rd_addr),
      .line_end (raster_line_end),
      .last     (raster_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = dim_zero ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (!pause && raster_last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (writes_complete) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State-decoded outputs; processor results are only accepted while busy
   always_comb begin
      busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      done      = (state_q == ST_DONE);
      rd_en     = (state_q == ST_RUN) && !pause;
      line_done = rd_en && raster_line_end;
      wr_en     = proc_valid_out && busy;
   end

   // Config capture on an accepted start, read-valid pipeline and write address
   always_comb begin
      width_d   = width_q;
      height_d  = height_q;
      total_d   = total_q;
      op_d      = op_q;
      thresh_d  = thresh_q;
      bright_d  = bright_q;
      pvalid_d  = rd_en;
      wr_addr_d = wr_addr_q;
      if (start_ok) begin
         width_d   = img_width;
         height_d  = img_height;
         total_d   = ADDR_W'(img_width) * ADDR_W'(img_height);
         op_d      = op_sel;
         thresh_d  = thresh_cfg;
         bright_d  = bright_cfg;
         wr_addr_d = '0;
      end else if (wr_en) begin
         wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         width_q   <= '0;
         height_q  <= '0;
         total_q   <= '0;
         op_q      <= '0;
         thresh_q  <= '0;
         bright_q  <= '0;
         pvalid_q  <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         width_q   <= width_d;
         height_q  <= height_d;
         total_q   <= total_d;
         op_q      <= op_d;
         thresh_q  <= thresh_d;
         bright_q  <= bright_d;
         pvalid_q  <= pvalid_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   assign proc_pixel_in = rd_data;
   assign proc_valid_in = pvalid_q;
   assign proc_op       = op_q;
   assign proc_thresh   = thresh_q;
   assign proc_bright   = bright_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = proc_pixel_out;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Self-checking bench for image_frame_sequencer: models the source memory and
// the pixel processor, logs every DUT transaction, and compares each frame
// against the expected raster order, addresses, data and timing.
module tb_image_frame_sequencer;
   import img_pkg::*;

   localparam int DIM_W  = 10;
   localparam int ADDR_W = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DIM_W-1:0]  img_width;
   logic [DIM_W-1:0]  img_height;
   logic [1:0]        op_sel;
   logic [7:0]        thresh_cfg;
   logic [7:0]        bright_cfg;
   logic              pause;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [23:0]       rd_data;
   logic [23:0]       proc_pixel_in;
   logic              proc_valid_in;
   logic [1:0]        proc_op;
   logic [7:0]        proc_thresh;
   logic [7:0]        proc_bright;
   logic [23:0]       proc_pixel_out;
   logic              proc_valid_out = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              line_done;

   always #5 clk = ~clk;

   image_frame_sequencer #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
      .op_sel(op_sel), .thresh_cfg(thresh_cfg), .bright_cfg(bright_cfg), .pause(pause),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .proc_pixel_in(proc_pixel_in), .proc_valid_in(proc_valid_in), .proc_op(proc_op),
      .proc_thresh(proc_thresh), .proc_bright(proc_bright), .proc_pixel_out(proc_pixel_out),
      .proc_valid_out(proc_valid_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .line_done(line_done)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [23:0] src_mem [0:255];

   typedef struct {
      int          addr;
      logic [23:0] data;
      int          cyc;
   } wr_t;

   int  rd_addr_log[$];
   int  rd_cyc_log[$];
   int  ld_log[$];
   int  done_log[$];
   bit  done_busy_log[$];
   wr_t wr_log[$];

   // Reference pixel processor behaviour
   function automatic logic [23:0] pix_op(input logic [23:0] p, input logic [1:0] op,
                                          input logic [7:0] th, input logic [7:0] br);
      logic [23:0] r;
      int          s;
      r = '0;
      case (op)
         OP_INVERT: r = ~p;
         OP_THRESH: for (int c = 0; c < 3; c++) r[c*8 +: 8] = (p[c*8 +: 8] >= th) ? 8'hFF : 8'h00;
         OP_BRIGHT: for (int c = 0; c < 3; c++) begin
            s = int'(p[c*8 +: 8]) + int'(br);
            r[c*8 +: 8] = (s > 255) ? 8'hFF : s[7:0];
         end
         default: begin
            s = (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
            r = {3{s[7:0]}};
         end
      endcase
      return r;
   endfunction

   // Source memory with 1-cycle read latency and processor with 1-cycle latency
   always @(posedge clk) begin
      cyc            <= cyc + 1;
      proc_valid_out <= proc_valid_in;
      proc_pixel_out <= pix_op(proc_pixel_in, proc_op, proc_thresh, proc_bright);
      if (rd_en) rd_data <= src_mem[rd_addr[7:0]];
   end

   // Transaction logging, sampled mid-cycle
   always @(negedge clk) begin
      if (rd_en) begin
         rd_addr_log.push_back(int'(rd_addr));
         rd_cyc_log.push_back(cyc);
         $display("[TB] cyc %0d read  addr %0d", cyc, rd_addr);
      end
      if (line_done) ld_log.push_back(int'(rd_addr));
      if (wr_en) begin
         wr_log.push_back('{int'(wr_addr), wr_data, cyc});
         $display("[TB] cyc %0d write addr %0d data %06h", cyc, wr_addr, wr_data);
      end
      if (done) begin
         done_log.push_back(cyc);
         done_busy_log.push_back(busy);
         $display("[TB] cyc %0d done", cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s did not hold", tag);
      end
   endtask

   task automatic clear_logs();
      rd_addr_log.delete();
      rd_cyc_log.delete();
      ld_log.delete();
      done_log.delete();
      done_busy_log.delete();
      wr_log.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"},          64'(busy), 64'(0));
      check({tag, " done"},          64'(done), 64'(0));
      check({tag, " rd_en"},         64'(rd_en), 64'(0));
      check({tag, " rd_addr"},       64'(rd_addr), 64'(0));
      check({tag, " proc_valid_in"}, 64'(proc_valid_in), 64'(0));
      check({tag, " wr_addr"},       64'(wr_addr), 64'(0));
      check({tag, " wr_en"},         64'(wr_en), 64'(0));
      check({tag, " line_done"},     64'(line_done), 64'(0));
      check({tag, " proc_op"},       64'(proc_op), 64'(0));
      check({tag, " proc_thresh"},   64'(proc_thresh), 64'(0));
      check({tag, " proc_bright"},   64'(proc_bright), 64'(0));
   endtask

   // Runs one frame starting in the current cycle; returns one cycle after done
   task automatic run_frame(input int w, input int h, input logic [1:0] op,
                            input logic [7:0] th, input logic [7:0] br,
                            input int pause_at, input int pause_len,
                            input bit mid_start, input bit settle, input string name);
      int start_cyc, n, padd, paused, exp_cyc, shift;
      bit got;
      int exp_ld[$];
      clear_logs();
      n = w * h;
      padd = (pause_at >= 0 && pause_at < n) ? pause_len : 0;
      start_cyc  = cyc;
      img_width  = DIM_W'(w);
      img_height = DIM_W'(h);
      op_sel     = op;
      thresh_cfg = th;
      bright_cfg = br;
      start      = 1'b1;
      $display("[TB] %s: start %0dx%0d op %0d th %02h br %02h", name, w, h, op, th, br);
      @(posedge clk); #1;
      start      = 1'b0;
      img_width  = DIM_W'($urandom);
      img_height = DIM_W'($urandom);
      op_sel     = op ^ 2'b01;
      thresh_cfg = 8'($urandom);
      bright_cfg = 8'($urandom);
      got = 1'b0;
      paused = 0;
      for (int c = 0; c < 500 && !got; c++) begin
         pause = 1'b0;
         if (pause_at >= 0 && rd_addr_log.size() == pause_at && paused < pause_len) begin
            pause = 1'b1;
            paused++;
         end
         start = mid_start && (c == 3);
         @(negedge clk);
         if (done_log.size() != 0) got = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      pause = 1'b0;
      if (settle) repeat (4) begin @(posedge clk); #1; end

      check({name, " done_seen"}, 64'(got), 64'(1));
      check({name, " done_count"}, 64'(done_log.size()), 64'(1));
      if (done_log.size() > 0) begin
         exp_cyc = (n == 0) ? start_cyc + 1 : start_cyc + n + padd + 3;
         check({name, " done_cycle"}, 64'(done_log[0]), 64'(exp_cyc));
         check({name, " busy_in_done"}, 64'(done_busy_log[0]), 64'(0));
      end
      check({name, " rd_count"}, 64'(rd_addr_log.size()), 64'(n));
      check({name, " wr_count"}, 64'(wr_log.size()), 64'(n));
      for (int i = 0; i < n && i < rd_addr_log.size(); i++) begin
         shift = (pause_at >= 0 && i >= pause_at) ? pause_len : 0;
         check($sformatf("%s rd_addr[%0d]", name, i), 64'(rd_addr_log[i]), 64'(i));
         check($sformatf("%s rd_cyc[%0d]", name, i), 64'(rd_cyc_log[i]), 64'(start_cyc + 1 + i + shift));
      end
      for (int i = 0; i < n && i < wr_log.size(); i++) begin
         shift = (pause_at >= 0 && i >= pause_at) ? pause_len : 0;
         check($sformatf("%s wr_addr[%0d]", name, i), 64'(wr_log[i].addr), 64'(i));
         check($sformatf("%s wr_data[%0d]", name, i), 64'(wr_log[i].data),
               64'(pix_op(src_mem[i], op, th, br)));
         check($sformatf("%s wr_cyc[%0d]", name, i), 64'(wr_log[i].cyc), 64'(start_cyc + 3 + i + shift));
      end
      for (int i = 0; i < n; i++) if (i % w == w - 1) exp_ld.push_back(i);
      check({name, " line_done_count"}, 64'(ld_log.size()), 64'(exp_ld.size()));
      for (int i = 0; i < exp_ld.size() && i < ld_log.size(); i++)
         check($sformatf("%s line_done[%0d]", name, i), 64'(ld_log[i]), 64'(exp_ld[i]));
      check({name, " proc_op"},     64'(proc_op), 64'(op));
      check({name, " proc_thresh"}, 64'(proc_thresh), 64'(th));
      check({name, " proc_bright"}, 64'(proc_bright), 64'(br));
      check({name, " busy_after"},  64'(busy), 64'(0));
   endtask

   initial begin
      int w, h, pa;
      rst = 1'b1; start = 1'b0; pause = 1'b0;
      img_width = '0; img_height = '0; op_sel = '0; thresh_cfg = '0; bright_cfg = '0;
      for (int i = 0; i < 256; i++) src_mem[i] = 24'(i);
      repeat (3) begin @(posedge clk); #1; end
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      run_frame(4, 2, OP_INVERT, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, "f4x2_invert");
      run_frame(4, 2, OP_INVERT, 8'h00, 8'h00, 2, 3, 1'b0, 1'b1, "f4x2_pause");
      run_frame(0, 5, OP_INVERT, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, "f0x5");
      run_frame(3, 0, OP_GRAY, 8'h10, 8'h20, -1, 0, 1'b0, 1'b1, "f3x0");
      run_frame(4, 2, OP_BRIGHT, 8'h11, 8'h40, -1, 0, 1'b1, 1'b1, "f4x2_midstart");

      // Reset in the cycle read 3 of a 4x4 frame is issued
      for (int i = 0; i < 256; i++) src_mem[i] = 24'($urandom);
      clear_logs();
      img_width = DIM_W'(4); img_height = DIM_W'(4); op_sel = OP_BRIGHT;
      thresh_cfg = 8'h33; bright_cfg = 8'h44; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 50 && rd_addr_log.size() < 3; c++) begin @(posedge clk); #1; end
      check("rst_mid reached_read3", 64'(rd_addr_log.size()), 64'(3));
      check("rst_mid rd_en_at_read3", 64'(rd_en), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("rst_mid");
      repeat (8) begin @(posedge clk); #1; end
      check("rst_mid no_done", 64'(done_log.size()), 64'(0));
      run_frame(4, 4, OP_THRESH, 8'h90, 8'h00, -1, 0, 1'b0, 1'b1, "f4x4_after_rst");

      // Back-to-back frames: second start in the cycle after done
      run_frame(3, 1, OP_GRAY, 8'h00, 8'h00, -1, 0, 1'b0, 1'b0, "b2b_gray");
      run_frame(2, 2, OP_THRESH, 8'h80, 8'h00, -1, 0, 1'b0, 1'b1, "b2b_thresh");

      // Randomized frames, pause sometimes landing in the drain phase
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 256; i++) src_mem[i] = 24'($urandom);
         w  = $urandom_range(1, 6);
         h  = $urandom_range(1, 6);
         pa = (k == 0) ? -1 : (k == 1) ? w * h : int'($urandom_range(0, w * h));
         run_frame(w, h, 2'($urandom), 8'($urandom), 8'($urandom), pa,
                   int'($urandom_range(1, 4)), 1'b0, 1'b1, $sformatf("rand%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/image_frame_sequencer.md
Name: image_frame_sequencer

Overview:
Frame-level controller for the team's RGB888 pixel processor (invert/threshold/brightness/grayscale, 1-cycle registered latency). On a start pulse it latches the frame configuration and raster-scans a source pixel memory (1-cycle read latency). It streams the pixels through the processor and writes the results linearly into a destination memory. It reports busy and done, and supports pausing the read side mid-frame.

Parameters:
DIM_W, 10, width of img_width/img_height (max 1023x1023)
ADDR_W, 20, memory address width; must be >= 2*DIM_W

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  single-cycle frame start request
img_width  input  DIM_W  pixels per line, sampled on accepted start
img_height  input  DIM_W  lines per frame, sampled on accepted start
op_sel  input  2  operation (00 invert, 01 threshold, 10 brightness, 11 grayscale), sampled on start
thresh_cfg  input  8  threshold value, sampled on start
bright_cfg  input  8  brightness value, sampled on start
pause  input  1  when high, no new reads are issued
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the last write has been issued
rd_en  output  1  source memory read strobe
rd_addr  output  ADDR_W  source read address
rd_data  input  24  source pixel, valid the cycle after rd_en
proc_pixel_in  output  24  to processor pixel input (= rd_data, combinational)
proc_valid_in  output  1  to processor valid input
proc_op  output  2  latched op_sel
proc_thresh  output  8  latched thresh_cfg
proc_bright  output  8  latched bright_cfg
proc_pixel_out  input  24  from processor
proc_valid_out  input  1  from processor
wr_en  output  1  destination write strobe (= proc_valid_out while busy)
wr_addr  output  ADDR_W  destination write address
wr_data  output  24  destination data (= proc_pixel_out)
line_done  output  1  one-cycle pulse when the read side issues the last pixel of a line

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, proc_valid_in=0, wr_addr=0, line_done=0. proc_op, proc_thresh and proc_bright reset to 0.
- Reset mid-frame: the machine returns to IDLE at once, no done pulse, and the counters are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches the config and total = width*height (registered product), then goes to RUN. If width or height is 0, it goes straight to DONE and no memory accesses occur.
  - RUN: each cycle with pause=0, assert rd_en and rd_addr = read index, then advance x and y. x wraps at width-1 with y++. On the last pixel (x=w-1, y=h-1), line_done pulses and the FSM goes to DRAIN. With pause=1, rd_en=0 and the counters hold.
  - DRAIN: waits until the write count equals total, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy=0 in the DONE cycle.
- proc_valid_in is rd_en registered by one cycle. Read-to-write latency is exactly 2 cycles: rd_en at cycle t gives wr_en at t+2.
- wr_addr starts at 0 and increments after each wr_en. proc_valid_out is ignored when not busy.
- Latched config stays stable for the whole frame. start while busy, or in the DONE cycle, is ignored.
- pause during DRAIN has no effect; in-flight pixels always complete.
- Pixel ordering is preserved; the write index always equals the read index of the same pixel.
- Counters are unsigned. read index = y*width + x, kept as a running counter rather than a multiply.

Decomposition:
- Shared package img_pkg: op encodings (OP_INVERT=2'b00, OP_THRESH=2'b01, OP_BRIGHT=2'b10, OP_GRAY=2'b11), the RGB888 pixel width constant (24), and the FSM state enum.
- One sub-module is natural: image_raster_counter. It owns the x/y/linear-index counters, with enable, wrap, and last/line-end flags.

Test Plan:
- 4x2 frame, invert, memory holding index values, no pause: rd_addr 0..7 on consecutive cycles; first wr_en 2 cycles after the first rd_en; wr_data = ~pixel; done 1 cycle after the 8th write; line_done at reads 3 and 7.
- Same 4x2 frame with pause=1 for 3 cycles after the 2nd read: reads resume at rd_addr 2; all 8 writes land at addresses 0..7 in order; done is delayed by 3 cycles.
- width=0, height=5, start: no rd_en or wr_en; done pulses 1 cycle after start.
- start re-asserted mid-frame with op_sel changed: ignored; proc_op holds its original value; the frame completes with one done.
- rst asserted at read 3 of a 4x4 frame: all outputs return to reset values next cycle and there is no done; a new start runs a full clean frame from address 0.
- Back-to-back frames: start in the cycle after done (3x1 grayscale, then 2x2 threshold thresh=0x80): the second frame's addresses restart at 0, and the config switches correctly between frames.
